// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction-fetch slice.
//   NOP_INSTR        : instruction presented on InstrF when no entry is valid
//   RESET_PC_DEFAULT : default fetch address after reset
//   fetch_entry_t    : one buffered fetch result {instr, pc}
//   pc_plus4         : 32-bit PC increment, wraps at 2^32
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0033;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Synchronous FIFO used both as the fetch buffer and as the in-order PC queue.
//   clk, reset : clock, synchronous active-high reset
//   flush      : empties the FIFO at the clock edge (overrides push/pop)
//   push, din  : write an entry; accepted when not full or when popping in the same cycle
//   pop, dout  : dout is the head entry; pop removes it (ignored when empty)
//   full, empty, count : occupancy status
module fetch_buffer
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter type T = fetch_entry_t
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         push,
  input  T                             din,
  input  logic                         pop,
  output T                             dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  T               mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !reset && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch producer for the IF/ID interface.
//   clk, reset          : clock, synchronous active-high reset
//   StallF              : IF/ID holding, head entry is not consumed
//   PCSrcE, PCTargetE   : redirect fetch to PCTargetE (overrides StallF)
//   ImemReq, ImemAddr   : request to instruction memory; ImemGnt accepts it
//   ImemRvalid, ImemRdata : in-order responses from instruction memory
//   InstrF, PCF, PCPlus4F, ValidF : head of the fetch buffer (NOP/0 when empty)
module if_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int unsigned FBUF_DEPTH  = 2,
  parameter int unsigned MAX_OUTSTND = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemGnt,
  input  logic        ImemRvalid,
  input  logic [31:0] ImemRdata,
  output logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic        ValidF
);

  localparam int unsigned OW = $clog2(MAX_OUTSTND + 1);
  localparam int unsigned CW = $clog2(FBUF_DEPTH + 1);

  logic [31:0]   fetch_pc;
  logic [OW-1:0] outstanding;
  logic [OW-1:0] drop_cnt;
  logic [CW-1:0] occupancy;

  logic          issue;
  logic          rsp;
  logic          rsp_keep;
  logic          fbuf_pop;
  logic          fbuf_full;
  logic          fbuf_empty;
  fetch_entry_t  fbuf_in;
  fetch_entry_t  head;

  logic [31:0]   pcq_head;
  logic          pcq_full;
  logic          pcq_empty;
  logic [OW-1:0] pcq_count;

  // Credit rule: every granted request already owns a buffer slot, so the
  // buffer cannot overflow whatever the consumer does.
  assign ImemReq  = !reset && !PCSrcE
                 && ((32'(outstanding) + 32'(occupancy)) < FBUF_DEPTH)
                 && (32'(outstanding) < MAX_OUTSTND);
  assign ImemAddr = fetch_pc;
  assign issue    = ImemReq && ImemGnt;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp      = ImemRvalid && (outstanding != '0);
  assign rsp_keep = rsp && (drop_cnt == '0) && !PCSrcE;
  assign fbuf_pop = !fbuf_empty && !StallF && !PCSrcE;
  assign fbuf_in  = '{instr: ImemRdata, pc: pcq_head};

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (PCSrcE) begin
      // No issue happens in a redirect cycle; everything still in flight is stale.
      fetch_pc    <= PCTargetE;
      outstanding <= outstanding - OW'(rsp);
      drop_cnt    <= outstanding - OW'(rsp);
    end else begin
      if (issue) fetch_pc <= pc_plus4(fetch_pc);
      outstanding <= outstanding + OW'(issue) - OW'(rsp);
      if (rsp && (drop_cnt != '0)) drop_cnt <= drop_cnt - OW'(1);
    end
  end

  // Stale PCs are flushed on redirect, so the queue only ever holds PCs whose
  // responses will be kept; dropped responses never pop it.
  fetch_buffer #(
    .DEPTH (MAX_OUTSTND),
    .T     (logic [31:0])
  ) u_pc_queue (
    .clk   (clk),
    .reset (reset),
    .flush (PCSrcE),
    .push  (issue),
    .din   (fetch_pc),
    .pop   (rsp_keep),
    .dout  (pcq_head),
    .full  (pcq_full),
    .empty (pcq_empty),
    .count (pcq_count)
  );

  fetch_buffer #(
    .DEPTH (FBUF_DEPTH),
    .T     (fetch_entry_t)
  ) u_fetch_buf (
    .clk   (clk),
    .reset (reset),
    .flush (PCSrcE),
    .push  (rsp_keep),
    .din   (fbuf_in),
    .pop   (fbuf_pop),
    .dout  (head),
    .full  (fbuf_full),
    .empty (fbuf_empty),
    .count (occupancy)
  );

  always_comb begin
    ValidF   = !fbuf_empty;
    InstrF   = NOP_INSTR;
    PCF      = '0;
    PCPlus4F = '0;
    if (!fbuf_empty) begin
      InstrF   = head.instr;
      PCF      = head.pc;
      PCPlus4F = pc_plus4(head.pc);
    end
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (reset)
    !(rsp_keep && fbuf_full && !fbuf_pop));
  a_rsp_protocol : assert property (@(posedge clk) disable iff (reset)
    !(ImemRvalid && (outstanding == '0)));
  a_pcq_no_overflow : assert property (@(posedge clk) disable iff (reset)
    !(issue && pcq_full));
  a_pcq_has_pc : assert property (@(posedge clk) disable iff (reset)
    !(rsp_keep && pcq_empty));
  a_pcq_bounded : assert property (@(posedge clk) disable iff (reset)
    (32'(pcq_count) <= 32'(outstanding)));

endmodule
